// File: rtl/seq_ser_pkg.sv
// seq_ser_pkg: shared constants for the bit serializer.
// SEQ_SER_PARITY_EN adds a PARITY state that sends an even-parity bit after each repetition.
package seq_ser_pkg;

  localparam int DEF_MAX_LEN = 32;
  localparam int DEF_REP_W   = 8;

  // FSM encoding, kept as plain constants so older tools can consume it.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
`ifdef SEQ_SER_PARITY_EN
  localparam logic [1:0] ST_PARITY = 2'd2;
`endif

  // Width needed to hold a length value in the range 0..max_len.
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/seq_ser_shreg.sv
// seq_ser_shreg: loadable left-shifting pattern register with a bit counter.
// The pattern is left-aligned at load so the bit to send is always the MSB;
// a saved copy allows the frame to restart for repetitions without reloading.
// Under SEQ_SER_PARITY_EN it also presents the even parity of the saved pattern.
module seq_ser_shreg
  import seq_ser_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = len_w(DEF_MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_reload,
  input  logic               i_shift,
  input  logic [MAX_LEN-1:0] i_data,
  input  logic [LEN_W-1:0]   i_len,
  output logic               o_bit,
  output logic               o_last
`ifdef SEQ_SER_PARITY_EN
  ,
  output logic               o_parity
`endif
);

  logic [MAX_LEN-1:0] r_shreg;
  logic [MAX_LEN-1:0] r_saved;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_cnt;
  logic [MAX_LEN-1:0] w_aligned;

  // Move bit i_len-1 to the MSB; bits above the pattern fall off, zeros fill below.
  assign w_aligned = i_data << (LEN_W'(MAX_LEN) - i_len);

  // Load a new pattern, restart the saved one, or advance one bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg <= '0;
      r_saved <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
    end else if (i_load) begin
      r_shreg <= w_aligned;
      r_saved <= w_aligned;
      r_len   <= i_len;
      r_cnt   <= i_len - 1'b1;
    end else if (i_reload) begin
      r_shreg <= r_saved;
      r_cnt   <= r_len - 1'b1;
    end else if (i_shift) begin
      r_shreg <= r_shreg << 1;
      r_cnt   <= r_cnt - 1'b1;
    end
  end

  assign o_bit  = r_shreg[MAX_LEN-1];
  assign o_last = (r_cnt == '0);
`ifdef SEQ_SER_PARITY_EN
  // Zero fill means the reduction covers exactly the pattern bits.
  assign o_parity = ^r_saved;
`endif

endmodule

// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer: sends a parallel pattern MSB-first on x, one bit per clock,
// load_rep+1 times, with gapless back-to-back frames.
// Handshake: a pattern transfers on a rising edge where load_valid && load_ready
// && !abort; load_ready is high in IDLE and on the x_last cycle, so the next
// frame's first bit follows the previous frame's last bit with no gap.
// SEQ_SER_PARITY_EN: appends an even-parity bit after every repetition.
module seq_bit_serializer
  import seq_ser_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = len_w(MAX_LEN),
  parameter int REP_W   = DEF_REP_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [MAX_LEN-1:0] load_data,
  input  logic [LEN_W-1:0]   load_len,
  input  logic [REP_W-1:0]   load_rep,
  input  logic               abort,
  output logic               x,
  output logic               x_valid,
  output logic               x_last,
  output logic               busy,
  output logic [1:0]         dbg_state
);

  logic [1:0]       r_state;
  logic [REP_W-1:0] r_rep;
  logic [1:0]       w_next;
  logic [LEN_W-1:0] w_len;
  logic             w_xfer;
  logic             w_start;
  logic             w_reload;
  logic             w_shift;
  logic             w_rep_dec;
  logic             w_bit;
  logic             w_last_bit;
`ifdef SEQ_SER_PARITY_EN
  logic             w_parity;
`endif

  // Lengths above MAX_LEN are clamped; zero length is accepted but sends nothing.
  assign w_len   = (load_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : load_len;
  assign w_xfer  = load_valid && load_ready && !abort;
  assign w_start = w_xfer && (w_len != '0);

  seq_ser_shreg #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_shreg (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_start),
    .i_reload (w_reload),
    .i_shift  (w_shift),
    .i_data   (load_data),
    .i_len    (w_len),
    .o_bit    (w_bit),
    .o_last   (w_last_bit)
`ifdef SEQ_SER_PARITY_EN
    ,
    .o_parity (w_parity)
`endif
  );

  // Next-state and shift-register control decode.
  always_comb begin
    w_next    = r_state;
    w_reload  = 1'b0;
    w_shift   = 1'b0;
    w_rep_dec = 1'b0;
    case (r_state)
      ST_SHIFT: begin
        if (abort) begin
          w_next = ST_IDLE;
        end else if (!w_last_bit) begin
          w_shift = 1'b1;
`ifdef SEQ_SER_PARITY_EN
        end else begin
          w_next = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (abort) begin
          w_next = ST_IDLE;
`endif
        end else if (r_rep != '0) begin
          w_reload  = 1'b1;
          w_rep_dec = 1'b1;
          w_next    = ST_SHIFT;
        end else begin
          w_next = w_start ? ST_SHIFT : ST_IDLE;
        end
      end
      default: begin
        w_next = w_start ? ST_SHIFT : ST_IDLE;
      end
    endcase
  end

  // State register and repeat counter; the counter stops at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_rep   <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_rep <= load_rep;
      end else if (w_rep_dec) begin
        r_rep <= r_rep - 1'b1;
      end
    end
  end

`ifdef SEQ_SER_PARITY_EN
  assign x_last = (r_state == ST_PARITY) && (r_rep == '0);
  assign x      = (r_state == ST_SHIFT)  ? w_bit :
                  (r_state == ST_PARITY) ? w_parity : 1'b0;
`else
  assign x_last = (r_state == ST_SHIFT) && w_last_bit && (r_rep == '0);
  assign x      = (r_state == ST_SHIFT) ? w_bit : 1'b0;
`endif
  assign x_valid    = (r_state != ST_IDLE);
  assign busy       = (r_state != ST_IDLE);
  assign load_ready = (r_state == ST_IDLE) || x_last;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// tb_seq_bit_serializer: directed bench for seq_bit_serializer.
// Outputs are packed as {busy, x_valid, x, x_last, load_ready} and compared on
// the falling edge against an expected queue built from a per-bit frame model.
module tb_seq_bit_serializer;

  localparam int MAX_LEN = 32;
  localparam int LEN_W   = 6;
  localparam int REP_W   = 8;
  localparam logic [4:0] IDLE_V = 5'b00001;

  // ---------------- clock / reset / signals ----------------
  logic               clk = 1'b0;
  logic               rst;
  logic               load_valid;
  logic               load_ready;
  logic [MAX_LEN-1:0] load_data;
  logic [LEN_W-1:0]   load_len;
  logic [REP_W-1:0]   load_rep;
  logic               abort;
  logic               x;
  logic               x_valid;
  logic               x_last;
  logic               busy;
  logic [1:0]         dbg_state;
  logic [4:0]         obs;

  int n_vec = 0;
  int n_err = 0;
  logic [4:0] exp_q[$];

  always #5 clk = ~clk;

  assign obs = {busy, x_valid, x, x_last, load_ready};

  seq_bit_serializer #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W),
    .REP_W   (REP_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_len   (load_len),
    .load_rep   (load_rep),
    .abort      (abort),
    .x          (x),
    .x_valid    (x_valid),
    .x_last     (x_last),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // ---------------- model ----------------
  function automatic void push_frame(input logic [31:0] data, input int len, input int rep);
    int   l;
    logic p;
    logic last;
    l = (len > MAX_LEN) ? MAX_LEN : len;
    if (l == 0) return;
    p = 1'b0;
    for (int i = 0; i < l; i++) p = p ^ data[i];
    for (int r = 0; r <= rep; r++) begin
      for (int i = l - 1; i >= 0; i--) begin
`ifdef SEQ_SER_PARITY_EN
        last = 1'b0;
`else
        last = (r == rep) && (i == 0);
`endif
        exp_q.push_back({1'b1, 1'b1, data[i], last, last});
      end
`ifdef SEQ_SER_PARITY_EN
      exp_q.push_back({1'b1, 1'b1, p, r == rep, r == rep});
`endif
    end
  endfunction

  // ---------------- drivers ----------------
  task automatic drive_load(input logic [31:0] data, input int len, input int rep);
    load_valid = 1'b1;
    load_data  = data;
    load_len   = LEN_W'(len);
    load_rep   = REP_W'(rep);
  endtask

  task automatic drive_idle();
    load_valid = 1'b0;
    load_data  = '0;
    load_len   = '0;
    load_rep   = '0;
    abort      = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (obs !== IDLE_V || dbg_state !== 2'd0) begin
      n_err++;
      $display("FAIL reset_held obs=%b state=%0d exp=%b state=0", obs, dbg_state, IDLE_V);
    end
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (obs !== IDLE_V) begin
      n_err++;
      $display("FAIL reset_release obs=%b exp=%b", obs, IDLE_V);
    end
  endtask

  task automatic test_basic();
    logic [4:0] e;
    int k;
    push_frame(32'h1512B, 20, 0);
    exp_q.push_back(IDLE_V);
    exp_q.push_back(IDLE_V);
    @(negedge clk);
    drive_load(32'h1512B, 20, 0);
    @(negedge clk);
    k = 0;
    while (exp_q.size() > 0) begin
      load_valid = 1'b0;
      e = exp_q.pop_front();
      n_vec++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL basic cyc%0d obs=%b exp=%b", k + 1, obs, e);
      end
      k++;
      @(negedge clk);
    end
  endtask

  task automatic test_repeat();
    logic [4:0] e;
    int k;
    push_frame(32'h1, 3, 2);
    exp_q.push_back(IDLE_V);
    drive_load(32'h1, 3, 2);
    @(negedge clk);
    k = 0;
    while (exp_q.size() > 0) begin
      load_valid = 1'b0;
      e = exp_q.pop_front();
      n_vec++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL repeat cyc%0d obs=%b exp=%b", k + 1, obs, e);
      end
      k++;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] e;
    int k;
    int n1;
    push_frame(32'h4, 3, 0);
    n1 = exp_q.size();
    push_frame(32'h1, 3, 0);
    exp_q.push_back(IDLE_V);
    drive_load(32'h4, 3, 0);
    @(negedge clk);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL b2b cyc%0d obs=%b exp=%b", k + 1, obs, e);
      end
      if (k == n1 - 1) drive_load(32'h1, 3, 0);
      else load_valid = 1'b0;
      k++;
      @(negedge clk);
    end
  endtask

  task automatic test_abort();
    logic [4:0] e;
    push_frame(32'h1512B, 20, 0);
    drive_load(32'h1512B, 20, 0);
    @(negedge clk);
    load_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      e = exp_q.pop_front();
      n_vec++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL abort_pre cyc%0d obs=%b exp=%b", k + 1, obs, e);
      end
      if (k == 4) abort = 1'b1;
      @(negedge clk);
    end
    exp_q.delete();
    abort = 1'b0;
    n_vec++;
    if (obs !== IDLE_V) begin
      n_err++;
      $display("FAIL abort_cyc6 obs=%b exp=%b", obs, IDLE_V);
    end
    // abort in IDLE blocks a simultaneous offer
    abort = 1'b1;
    drive_load(32'h7, 3, 0);
    @(negedge clk);
    abort = 1'b0;
    load_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (obs !== IDLE_V) begin
        n_err++;
        $display("FAIL abort_idle_block cyc%0d obs=%b exp=%b", k, obs, IDLE_V);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_rst_mid();
    logic [4:0] e;
    push_frame(32'h1512B, 20, 3);
    drive_load(32'h1512B, 20, 3);
    @(negedge clk);
    load_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      e = exp_q.pop_front();
      n_vec++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL rst_pre cyc%0d obs=%b exp=%b", k + 1, obs, e);
      end
      if (k == 4) rst = 1'b1;
      @(negedge clk);
    end
    exp_q.delete();
    rst = 1'b0;
    n_vec++;
    if (obs !== IDLE_V || dbg_state !== 2'd0) begin
      n_err++;
      $display("FAIL rst_cyc6 obs=%b state=%0d exp=%b state=0", obs, dbg_state, IDLE_V);
    end
    @(negedge clk);
    n_vec++;
    if (obs !== IDLE_V) begin
      n_err++;
      $display("FAIL rst_cyc7 obs=%b exp=%b", obs, IDLE_V);
    end
  endtask

  task automatic test_len_zero();
    drive_load(32'hFFFF_FFFF, 0, 3);
    @(negedge clk);
    load_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (obs !== IDLE_V) begin
        n_err++;
        $display("FAIL len_zero cyc%0d obs=%b exp=%b", k + 1, obs, IDLE_V);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_len_clamp();
    logic [4:0] e;
    int k;
    push_frame(32'h8000_0001, 40, 0);
    exp_q.push_back(IDLE_V);
    drive_load(32'h8000_0001, 40, 0);
    @(negedge clk);
    k = 0;
    while (exp_q.size() > 0) begin
      load_valid = 1'b0;
      e = exp_q.pop_front();
      n_vec++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL len_clamp cyc%0d obs=%b exp=%b", k + 1, obs, e);
      end
      k++;
      @(negedge clk);
    end
  endtask

`ifdef SEQ_SER_PARITY_EN
  task automatic test_parity();
    logic [4:0] e;
    int k;
    push_frame(32'h5, 3, 0);
    exp_q.push_back(IDLE_V);
    drive_load(32'h5, 3, 0);
    @(negedge clk);
    k = 0;
    while (exp_q.size() > 0) begin
      load_valid = 1'b0;
      e = exp_q.pop_front();
      n_vec++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL parity cyc%0d obs=%b exp=%b", k + 1, obs, e);
      end
      k++;
      @(negedge clk);
    end
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_basic();
    test_repeat();
    test_back_to_back();
    test_abort();
    test_rst_mid();
    test_len_zero();
    test_len_clamp();
`ifdef SEQ_SER_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
